ber_test_sequencer: RTL and testbench

//  Sequences one complete free-space-optical BER run: bit-rate timing, PRBS-10 to the laser, link-delay alignment, error counting.

---
 rtl/ber_test_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ber_test_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_test_sequencer.sv
// ber_test_sequencer: start/align/measure/done controller for a PRBS-10 FSO BER run.
// Optional feature macro BER_ERROR_INJECT_EN adds i_InjectError to invert chosen bits.
module ber_test_sequencer #(
  parameter int CLK_HZ       = 16000000,
  parameter int BPS          = 1000,
  parameter int SAMPLE_PHASE = (CLK_HZ / BPS) / 2,
  parameter int MAX_DELAY    = 7,
  parameter int LOCK_BITS    = 32,
  parameter int PRBS_LEN     = 1023
) (
  input  logic        CLK,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic        i_ReceivedSignal,
`ifdef BER_ERROR_INJECT_EN
  input  logic        i_InjectError,
`endif
  output logic        o_PRBS,
  output logic        o_BitTick,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Locked,
  output logic [2:0]  o_Delay,
  output logic [13:0] o_ErrorCount,
  output logic [13:0] o_BitCount,
  output logic [1:0]  o_State
);

  localparam int P  = CLK_HZ / BPS;
  localparam int TW = (P > 1) ? $clog2(P) : 1;
  localparam int SW = $clog2(LOCK_BITS + 1);

  localparam logic [TW-1:0] T_LAST = TW'(P - 1);
  localparam logic [TW-1:0] T_SAMP = TW'(SAMPLE_PHASE);
  localparam logic [2:0]    D_LAST = 3'(MAX_DELAY);
  localparam logic [SW-1:0] S_LAST = SW'(LOCK_BITS - 1);
  localparam logic [13:0]   B_LAST = 14'(PRBS_LEN - 1);
  localparam logic [13:0]   E_MAX  = 14'h3fff;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [9:0]       lfsr;
  logic [MAX_DELAY:0] hist;
  logic [SW-1:0]    streak;
  logic             rx_meta;
  logic             rx_sync;
  logic             inv;

  logic busy;
  logic tick;
  logic sample;
  logic ref_bit;
  logic match;
  logic go;

  assign busy    = (state == ALIGN) || (state == MEASURE);
  assign tick    = busy && (timer == '0);
  assign sample  = busy && (timer == T_SAMP);
  assign ref_bit = hist[o_Delay];
  assign match   = (rx_sync == ref_bit);
  assign go      = i_Start && ((state == IDLE) || (state == DONE));

  assign o_PRBS    = lfsr[9] ^ inv;
  assign o_BitTick = tick;
  assign o_Busy    = busy;
  assign o_Done    = (state == DONE);
  assign o_State   = state;

  // Two-flop synchroniser for the asynchronous receiver comparator
  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
    end else begin
      rx_meta <= i_ReceivedSignal;
      rx_sync <= rx_meta;
    end
  end

`ifdef BER_ERROR_INJECT_EN
  // Latch an inversion request for the bit period that starts on this tick
  always_ff @(posedge CLK) begin
    if (i_Reset || go) begin
      inv <= 1'b0;
    end else if (tick) begin
      inv <= (state == MEASURE) && i_InjectError;
    end
  end
`else
  assign inv = 1'b0;
`endif

  // Bit-period timer, runs only during a run so DONE freezes the line
  always_ff @(posedge CLK) begin
    if (i_Reset || !busy || (timer == T_LAST)) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // PRBS-10 generator and history of true transmitted bits
  always_ff @(posedge CLK) begin
    if (i_Reset || go) begin
      lfsr <= 10'b0000000001;
      hist <= '0;
    end else if (tick) begin
      lfsr <= {lfsr[8:0], lfsr[6] ^ lfsr[9]};
      hist <= {hist[MAX_DELAY-1:0], lfsr[8]};
    end
  end

  // Run controller: delay search, lock, error counting
  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      state        <= IDLE;
      streak       <= '0;
      o_Delay      <= '0;
      o_Locked     <= 1'b0;
      o_BitCount   <= '0;
      o_ErrorCount <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (i_Start) begin
            state        <= ALIGN;
            streak       <= '0;
            o_Delay      <= '0;
            o_Locked     <= 1'b0;
            o_BitCount   <= '0;
            o_ErrorCount <= '0;
          end
        end
        ALIGN: begin
          if (sample) begin
            if (match) begin
              if (streak == S_LAST) begin
                state        <= MEASURE;
                streak       <= '0;
                o_Locked     <= 1'b1;
                o_BitCount   <= '0;
                o_ErrorCount <= '0;
              end else begin
                streak <= streak + 1'b1;
              end
            end else begin
              streak <= '0;
              if (o_Delay == D_LAST) begin
                state <= DONE;
              end else begin
                o_Delay <= o_Delay + 1'b1;
              end
            end
          end
        end
        MEASURE: begin
          if (sample) begin
            o_BitCount <= o_BitCount + 1'b1;
            if (!match && (o_ErrorCount != E_MAX)) begin
              o_ErrorCount <= o_ErrorCount + 1'b1;
            end
            if (o_BitCount == B_LAST) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_test_sequencer.sv
// tb_ber_test_sequencer: scoreboard bench for ber_test_sequencer.
// Define BER_ERROR_INJECT_EN on both files to cover the inject port.
module tb_ber_test_sequencer;

`ifdef BER_ERROR_INJECT_EN
  localparam int INJ_N = 10;
`else
  localparam int INJ_N = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx = 1'b0;
`ifdef BER_ERROR_INJECT_EN
  logic        inject = 1'b0;
`endif
  logic        prbs;
  logic        bit_tick;
  logic        busy;
  logic        done;
  logic        locked;
  logic [2:0]  delay;
  logic [13:0] err_count;
  logic [13:0] bit_count;
  logic [1:0]  st_o;

  always #5 clk = ~clk;

  ber_test_sequencer #(
    .CLK_HZ(16),
    .BPS(1),
    .SAMPLE_PHASE(8),
    .MAX_DELAY(7),
    .LOCK_BITS(32),
    .PRBS_LEN(1023)
  ) dut (
    .CLK(clk),
    .i_Reset(rst),
    .i_Start(start),
    .i_ReceivedSignal(rx),
`ifdef BER_ERROR_INJECT_EN
    .i_InjectError(inject),
`endif
    .o_PRBS(prbs),
    .o_BitTick(bit_tick),
    .o_Busy(busy),
    .o_Done(done),
    .o_Locked(locked),
    .o_Delay(delay),
    .o_ErrorCount(err_count),
    .o_BitCount(bit_count),
    .o_State(st_o)
  );

  typedef struct {
    int lk;
    int dl;
    int bc;
    int ec;
  } res_t;

  typedef struct {
    string nm;
    int mode;
    int st;
    int bc;
    int ec;
    int lk;
    int dl;
  } probe_t;

  bit     lfsr_q[$];
  res_t   res_q[$];
  probe_t pq[$];

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  // Link model: 0 = direct loopback, 1 = two-bit delay, 2 = tied low
  int rx_mode = 0;
  bit force_en = 1'b0;
  bit inj_en = 1'b0;
  logic [63:0] dline = '0;
  bit ptick = 1'b0;
  bit fz = 1'b0;
  int nf = 0;
`ifdef BER_ERROR_INJECT_EN
  int ni = 0;
`endif

  always @(negedge clk) begin
    logic src;
    if (!force_en) begin
      nf = 0;
      fz = 1'b0;
    end
    if (ptick && force_en) begin
      fz = 1'b0;
      if (st_o == 2'd2 && prbs && nf < 3 &&
          int'(bit_count) >= 100 * (nf + 1)) begin
        fz = 1'b1;
        nf++;
      end
    end
    case (rx_mode)
      0: src = prbs;
      1: src = dline[31];
      default: src = 1'b0;
    endcase
    rx = fz ? 1'b0 : src;
    dline = {dline[62:0], prbs};
`ifdef BER_ERROR_INJECT_EN
    if (!inj_en) ni = 0;
    inject = 1'b0;
    if (inj_en && bit_tick && st_o == 2'd2 && ni < INJ_N &&
        int'(bit_count) >= 400 + 20 * ni) begin
      inject = 1'b1;
      ni++;
    end
`endif
    ptick = bit_tick;
  end

  // Monitor: pops expectations as the DUT presents bits, results, probes
  bit mtick = 1'b0;
  bit mdone = 1'b0;

  always @(negedge clk) begin
    bit e;
    res_t r;
    probe_t p;
    if (mtick && lfsr_q.size() > 0) begin
      e = lfsr_q.pop_front();
      chk("lfsr_bit", int'(prbs), int'(e));
    end
    mtick = bit_tick;
    if (done && !mdone) begin
      if (res_q.size() == 0) begin
        chk("done_expected", res_q.size(), 1);
      end else begin
        r = res_q.pop_front();
        chk("res_locked", int'(locked), r.lk);
        chk("res_delay", int'(delay), r.dl);
        chk("res_bits", int'(bit_count), r.bc);
        chk("res_errors", int'(err_count), r.ec);
      end
    end
    mdone = done;
    if (pq.size() > 0) begin
      p = pq.pop_front();
      case (p.mode)
        0: chk(p.nm, int'(st_o), p.st);
        1: begin
          chk({p.nm, "_state"}, int'(st_o), p.st);
          chk({p.nm, "_bits"}, int'(bit_count), p.bc);
          chk({p.nm, "_errors"}, int'(err_count), p.ec);
          chk({p.nm, "_locked"}, int'(locked), p.lk);
          chk({p.nm, "_delay"}, int'(delay), p.dl);
        end
        2: begin
          chk({p.nm, "_state"}, int'(st_o), 0);
          chk({p.nm, "_bits"}, int'(bit_count), 0);
          chk({p.nm, "_errors"}, int'(err_count), 0);
          chk({p.nm, "_prbs"}, int'(prbs), 0);
          chk({p.nm, "_locked"}, int'(locked), 0);
          chk({p.nm, "_delay"}, int'(delay), 0);
          chk({p.nm, "_busy"}, int'(busy), 0);
          chk({p.nm, "_done"}, int'(done), 0);
          chk({p.nm, "_tick"}, int'(bit_tick), 0);
        end
        3: begin
          chk("res_q_drained", res_q.size(), 0);
          chk("lfsr_q_drained", lfsr_q.size(), 0);
        end
        default: chk(p.nm, int'(bit_count), p.bc);
      endcase
    end
  end

  task automatic probe(input string nm, input int mode, input int st,
                       input int bc, input int ec, input int lk,
                       input int dl);
    probe_t p;
    p.nm = nm;
    p.mode = mode;
    p.st = st;
    p.bc = bc;
    p.ec = ec;
    p.lk = lk;
    p.dl = dl;
    @(posedge clk);
    #1;
    pq.push_back(p);
  endtask

  task automatic push_res(input int lk, input int dl, input int bc,
                          input int ec);
    res_t r;
    r.lk = lk;
    r.dl = dl;
    r.bc = bc;
    r.ec = ec;
    res_q.push_back(r);
  endtask

  // Reference PRBS-10: seed 1, x^10 + x^7 + 1, first 20 bits after reseed
  task automatic push_lfsr();
    logic [9:0] s;
    s = 10'd1;
    for (int i = 0; i < 20; i++) begin
      s = {s[8:0], s[6] ^ s[9]};
      lfsr_q.push_back(s[9]);
    end
  endtask

  task automatic wait_state(input int st, input int budget, input string nm);
    int n;
    n = 0;
    while (int'(st_o) != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(st_o) != st) probe(nm, 0, st, 0, 0, 0, 0);
  endtask

  task automatic wait_bc(input int v, input int budget, input string nm);
    int n;
    n = 0;
    while (int'(bit_count) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(bit_count) != v) probe(nm, 4, 0, v, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    probe("reset", 2, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Two-bit delayed loopback, with ignored starts in ALIGN and MEASURE
    rx_mode = 1;
    push_res(1, 2, 1023, 0);
    @(negedge clk);
    start = 1'b1;
    push_lfsr();
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    probe("start_in_align", 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    wait_state(2, 3000, "wait_measure_a");
    repeat (100) @(negedge clk);
    start = 1'b1;
    probe("start_in_measure", 0, 2, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    wait_state(3, 20000, "wait_done_a");

    // Restart from DONE: direct loopback, three forced-low bits (+ injects)
    @(negedge clk);
    rx_mode = 0;
    force_en = 1'b1;
    inj_en = 1'b1;
    push_res(1, 0, 1023, 3 + INJ_N);
    push_lfsr();
    start = 1'b1;
    probe("restart_from_done", 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    wait_state(3, 20000, "wait_done_b");
    force_en = 1'b0;
    inj_en = 1'b0;

    // Receiver stuck low: every delay rejected
    @(negedge clk);
    rx_mode = 2;
    push_res(0, 7, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(3, 2000, "wait_done_c");

    // Reset out of DONE, then reset mid-MEASURE
    @(negedge clk);
    rst = 1'b1;
    probe("reset_after_done", 2, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    rx_mode = 1;
    start = 1'b1;
    push_lfsr();
    @(negedge clk);
    start = 1'b0;
    wait_bc(500, 20000, "wait_bits_500");
    rst = 1'b1;
    probe("reset_mid_measure", 2, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Clean rerun after the interrupted one
    push_res(1, 2, 1023, 0);
    start = 1'b1;
    push_lfsr();
    @(negedge clk);
    start = 1'b0;
    wait_state(3, 20000, "wait_done_e");

    repeat (5) @(negedge clk);
    probe("drain", 3, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
